// File: rtl/ahb_boot_master_if.sv
// AHB-Lite bus bundle between the boot master and the CPU subsystem slave port.
// Signal names match the master-side M_* port names.
interface ahb_boot_master_if;
  logic [31:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [2:0]  M_HSIZE;
  logic [2:0]  M_HBURST;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic [31:0] M_HRDATA;
  logic        M_HRESP;

  modport master (
    output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HWDATA,
    input  M_HREADY, M_HRDATA, M_HRESP
  );

  modport slave (
    input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HWDATA,
    output M_HREADY, M_HRDATA, M_HRESP
  );
endinterface

// File: rtl/ahb_boot_master.sv
// AHB-Lite boot sequencer: streams the ROM image into IM/DM, runs the CPU,
// polls for completion, stops it and fetches the result word.
module ahb_boot_master #(
  parameter logic [31:0] IM_BASE     = 32'h4000_0000,
  parameter int          IM_WORDS    = 40,
  parameter logic [31:0] DM_BASE     = 32'h4000_2000,
  parameter int          DM_WORDS    = 2048,
  parameter logic [31:0] CTRL_ADDR   = 32'h4000_8004,
  parameter logic [31:0] POLL_ADDR   = 32'h4000_4018,
  parameter logic [31:0] DONE_MAGIC  = 32'd1234,
  parameter logic [31:0] RESULT_ADDR = 32'h4000_3FFC,
  parameter logic [15:0] POLL_MAX    = 16'd65535,
  parameter int          ROM_AW      = 12
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [31:0]       result,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  ahb_boot_master_if.master m
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IM, S_LOAD_DM, S_RUN, S_POLL, S_STOP, S_READ_RES, S_DONE, S_ERR
  } state_t;

  // Tags an address phase so its data phase knows where HWDATA comes from
  // and what to do with HRDATA.
  typedef enum logic [1:0] {K_LOAD, K_CTRL, K_POLL, K_RES} kind_t;

  localparam logic [ROM_AW-1:0] IM_LAST  = ROM_AW'(IM_WORDS - 1);
  localparam logic [ROM_AW-1:0] ALL_LAST = ROM_AW'(IM_WORDS + DM_WORDS - 1);
  localparam logic [1:0]        TR_IDLE  = 2'b00;
  localparam logic [1:0]        TR_NSEQ  = 2'b10;

  state_t            r_state, w_state_n;
  logic              r_av, w_av_n;
  logic [31:0]       r_haddr, w_haddr_n;
  logic              r_hwrite, w_hwrite_n;
  kind_t             r_akind, w_akind_n;
  logic              r_awval, w_awval_n;
  logic              r_dv, w_dv_n;
  kind_t             r_dkind, w_dkind_n;
  logic              r_dwrite, w_dwrite_n;
  logic              r_dwval, w_dwval_n;
  logic [ROM_AW-1:0] r_idx, w_idx_n;
  logic [15:0]       r_pcnt, w_pcnt_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic              r_error, w_error_n;
  logic [1:0]        r_ecode, w_ecode_n;
  logic [31:0]       r_result, w_result_n;

  logic        w_acc, w_dfin, w_start_ok;
  logic [15:0] w_pinc;

  assign w_acc      = r_av & m.M_HREADY;
  assign w_dfin     = r_dv & m.M_HREADY;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_pinc     = r_pcnt + 16'd1;

  always_comb begin
    w_state_n  = r_state;
    w_av_n     = r_av;
    w_haddr_n  = r_haddr;
    w_hwrite_n = r_hwrite;
    w_akind_n  = r_akind;
    w_awval_n  = r_awval;
    w_dv_n     = r_dv;
    w_dkind_n  = r_dkind;
    w_dwrite_n = r_dwrite;
    w_dwval_n  = r_dwval;
    w_idx_n    = r_idx;
    w_pcnt_n   = r_pcnt;
    w_busy_n   = r_busy;
    w_done_n   = r_done;
    w_error_n  = r_error;
    w_ecode_n  = r_ecode;
    w_result_n = r_result;

    // Address phase moves into the data phase on every ready edge.
    if (m.M_HREADY) begin
      w_dv_n     = r_av;
      w_dkind_n  = r_akind;
      w_dwrite_n = r_hwrite;
      w_dwval_n  = r_awval;
    end

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start_ok) begin
          w_state_n  = S_LOAD_IM;
          w_busy_n   = 1'b1;
          w_done_n   = 1'b0;
          w_error_n  = 1'b0;
          w_ecode_n  = 2'b00;
          w_pcnt_n   = '0;
          w_idx_n    = '0;
          w_av_n     = 1'b1;
          w_haddr_n  = IM_BASE;
          w_hwrite_n = 1'b1;
          w_akind_n  = K_LOAD;
        end
      end
      S_LOAD_IM: begin
        if (w_acc) begin
          w_idx_n = r_idx + ROM_AW'(1);
          if (r_idx == IM_LAST) begin
            w_state_n = S_LOAD_DM;
            w_haddr_n = DM_BASE;
          end else begin
            w_haddr_n = r_haddr + 32'd4;
          end
        end
      end
      S_LOAD_DM: begin
        if (w_acc) begin
          if (r_idx == ALL_LAST) begin
            w_state_n = S_RUN;
            w_haddr_n = CTRL_ADDR;
            w_akind_n = K_CTRL;
            w_awval_n = 1'b1;
          end else begin
            w_idx_n   = r_idx + ROM_AW'(1);
            w_haddr_n = r_haddr + 32'd4;
          end
        end
      end
      S_RUN: begin
        if (w_acc) begin
          w_av_n    = 1'b0;
          w_state_n = S_POLL;
        end
      end
      S_POLL: begin
        // One read in flight at most; a new one only once the bus is empty.
        if (!r_av && !r_dv) begin
          w_av_n     = 1'b1;
          w_haddr_n  = POLL_ADDR;
          w_hwrite_n = 1'b0;
          w_akind_n  = K_POLL;
        end else if (w_acc) begin
          w_av_n = 1'b0;
        end
        if (w_dfin && r_dkind == K_POLL) begin
          w_pcnt_n = w_pinc;
          if (m.M_HRDATA == DONE_MAGIC) begin
            w_state_n  = S_STOP;
            w_av_n     = 1'b1;
            w_haddr_n  = CTRL_ADDR;
            w_hwrite_n = 1'b1;
            w_akind_n  = K_CTRL;
            w_awval_n  = 1'b0;
          end else if (w_pinc >= POLL_MAX) begin
            w_state_n = S_ERR;
            w_busy_n  = 1'b0;
            w_error_n = 1'b1;
            w_ecode_n = 2'b10;
          end
        end
      end
      S_STOP: begin
        if (w_acc) begin
          w_state_n  = S_READ_RES;
          w_haddr_n  = RESULT_ADDR;
          w_hwrite_n = 1'b0;
          w_akind_n  = K_RES;
        end
      end
      S_READ_RES: begin
        if (w_acc) w_av_n = 1'b0;
        if (w_dfin && r_dkind == K_RES) begin
          w_result_n = m.M_HRDATA;
          w_state_n  = S_DONE;
          w_busy_n   = 1'b0;
          w_done_n   = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // An error response aborts everything, including a pipelined address phase.
    if (r_dv && m.M_HRESP) begin
      w_state_n = S_ERR;
      w_av_n    = 1'b0;
      w_dv_n    = 1'b0;
      w_busy_n  = 1'b0;
      w_done_n  = 1'b0;
      w_error_n = 1'b1;
      w_ecode_n = 2'b01;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_av     <= 1'b0;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_akind  <= K_LOAD;
      r_awval  <= 1'b0;
      r_dv     <= 1'b0;
      r_dkind  <= K_LOAD;
      r_dwrite <= 1'b0;
      r_dwval  <= 1'b0;
      r_idx    <= '0;
      r_pcnt   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_ecode  <= 2'b00;
      r_result <= '0;
    end else begin
      r_av     <= w_av_n;
      r_haddr  <= w_haddr_n;
      r_hwrite <= w_hwrite_n;
      r_akind  <= w_akind_n;
      r_awval  <= w_awval_n;
      r_dv     <= w_dv_n;
      r_dkind  <= w_dkind_n;
      r_dwrite <= w_dwrite_n;
      r_dwval  <= w_dwval_n;
      r_idx    <= w_idx_n;
      r_pcnt   <= w_pcnt_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_error  <= w_error_n;
      r_ecode  <= w_ecode_n;
      r_result <= w_result_n;
    end
  end

  // ROM read fires only when the load address phase is accepted, so rom_rdata
  // stays put for the whole (possibly stalled) data phase that forwards it.
  assign rom_en   = r_av & (r_akind == K_LOAD) & m.M_HREADY;
  assign rom_addr = r_idx;

  assign m.M_HADDR  = r_haddr;
  assign m.M_HTRANS = r_av ? TR_NSEQ : TR_IDLE;
  assign m.M_HWRITE = r_hwrite;
  assign m.M_HSIZE  = 3'b010;
  assign m.M_HBURST = 3'b000;
  assign m.M_HWDATA = !(r_dv && r_dwrite) ? 32'h0 :
                      (r_dkind == K_LOAD) ? rom_rdata : {31'h0, r_dwval};

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_ecode;
  assign result   = r_result;

endmodule
